xor_share_arbiter: RTL and testbench
====================================

Name: xor_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one parameterized XOR-mask datapath (data ^ MASK, width WIDTH) among NREQ requesters.
- Each requester has a valid/ready input handshake. One registered result stage with valid/ready drains results to a single consumer.
- Sits in front of the parameterized-width XOR unit and replaces per-requester instances of it.

Parameters:
- WIDTH, 3, datapath width in bits (>=1)
- NREQ, 2, number of requesters (2..8)
- MASK, 0, constant XOR operand, truncated/zero-extended to WIDTH
- IDW, 3, width of requester index; must satisfy 2**IDW >= NREQ

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NREQ  bit i = requester i has data
- req_data  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- req_ready  output  NREQ  one-hot grant/accept, combinational
- out_valid  output  1  result register holds valid data
- out_data  output  WIDTH  registered req_data[granted] ^ MASK
- out_id  output  IDW  index of the requester that produced out_data
- out_ready  input  1  consumer accepts result when out_valid & out_ready
- grant_cnt  output  NREQ*8  only with XSA_STATS_EN; see Optional Feature

Behaviour:
- Reset (reset=1 at clock edge):
  - out_valid=0, out_data=0, out_id=0.
  - Round-robin pointer rr_ptr=0; FSM to IDLE.
  - req_ready=0 during the reset cycle.
- FSM states:
  - IDLE: result register empty.
  - FULL: result register valid, waiting for out_ready.
- Accept condition: can_take = (state==IDLE) | out_ready.
  - req_ready is nonzero only when can_take=1 and at least one req_valid is set.
- Arbitration:
  - Scan requesters starting at rr_ptr, upward with wrap at NREQ-1 -> 0.
  - The first i with req_valid[i]=1 is granted: req_ready[i]=1, all other bits 0.
  - Purely combinational from req_valid, rr_ptr and state.
- On grant (handshake on requester i):
  - Next edge: out_data <= req_data[i] ^ MASK, out_id <= i, out_valid <= 1, state -> FULL.
  - rr_ptr <= (i==NREQ-1) ? 0 : i+1.
- Output drain without a new grant:
  - In FULL with out_ready=1 and no req_valid: out_valid <= 0, state -> IDLE.
  - out_data and out_id hold their last values.
- Output stall: in FULL with out_ready=0, no grant; out_data/out_id/out_valid held stable. Stall must never corrupt the held result.
- Simultaneous drain and grant: in FULL with out_ready=1 and a req_valid set, the result is replaced in the same cycle (back-to-back). Throughput is 1 result/cycle; latency is 1 cycle from grant to out_valid.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.
- Requester-side requirement: requesters hold req_data stable while req_valid=1 and not granted. The arbiter does not check this.
- Reset mid-operation: a pending result is discarded (out_valid=0 next edge); no grant is issued in the reset cycle.
- Widths:
  - XOR is bitwise at exactly WIDTH bits; MASK bits above WIDTH are ignored.
  - rr_ptr is IDW bits and never exceeds NREQ-1.

Optional Feature:
- Macro: XSA_STATS_EN.
- Defined:
  - Port grant_cnt present: NREQ 8-bit counters, counter i at [i*8 +: 8].
  - Counter i increments on each grant to requester i and saturates at 255 (no wrap).
  - All counters clear on reset.
- Undefined: no grant_cnt port, no counter logic; all other behaviour identical.

Test Plan:
- Reset check: hold reset 2 cycles with req_valid=2'b11 -> req_ready=0, out_valid=0, out_data=0; after release, first grant goes to requester 0.
- Round-robin with WIDTH=3, MASK=3'b101, NREQ=2:
  - req_valid=2'b11 held, data0=3'b000, data1=3'b011, out_ready=1.
  - out_id alternates 0,1,0,1 every cycle; out_data alternates 3'b101, 3'b110.
- Backpressure:
  - out_ready=0 after the first result (id0, data 3'b101) -> out_valid stays 1, out_data/out_id stable for 5 cycles, req_ready=0.
  - Raise out_ready -> requester 1 granted that same cycle.
- Drain to IDLE: single request from requester 1 with data 3'b111, out_ready=1 -> out_data=3'b010 for one cycle, then out_valid=0 with no further grants.
- Reset mid-stall: state FULL with out_ready=0, assert reset -> out_valid=0 next edge, rr_ptr=0, held result lost.
- With XSA_STATS_EN, NREQ=2: grant requester 0 300 times and requester 1 3 times -> grant_cnt[7:0]=255 (saturated), grant_cnt[15:8]=3.

Source files
------------

// File: rtl/xor_share_arbiter.sv
// rtl/xor_share_arbiter.sv - round-robin arbiter sharing one XOR-mask datapath among NREQ requesters
// Optional grant statistics counters are built when XSA_STATS_EN is defined.
module xor_share_arbiter #(
   parameter int              WIDTH = 3,
   parameter int              NREQ  = 2,
   parameter longint unsigned MASK  = 0,
   parameter int              IDW   = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [IDW-1:0]        out_id,
   input  logic                  out_ready
`ifdef XSA_STATS_EN
   ,
   output logic [NREQ*8-1:0]     grant_cnt
`endif
);

   localparam logic [WIDTH-1:0] MASK_W = WIDTH'(MASK);

   typedef enum logic {IDLE, FULL} state_t;

   state_t            state, state_nxt;
   logic [IDW-1:0]    rr_ptr;
   logic [2*NREQ-1:0] dbl_valid;
   logic [NREQ-1:0]   rot_valid;
   logic              grant_any;
   logic              can_take;
   logic              grant;
   logic [IDW-1:0]    grant_idx;
   logic [WIDTH-1:0]  sel_data;

   // Rotate requests so that rr_ptr sits at bit 0; the lowest set bit wins.
   always_comb begin
      dbl_valid = {req_valid, req_valid};
      rot_valid = NREQ'(dbl_valid >> rr_ptr);
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            grant_any = 1'b1;
            if (int'(rr_ptr) + k >= NREQ)
               grant_idx = rr_ptr + IDW'(k) - IDW'(NREQ);
            else
               grant_idx = rr_ptr + IDW'(k);
         end
      end
   end

   assign can_take  = (state == IDLE) | out_ready;
   assign grant     = grant_any & can_take & ~reset;
   assign req_ready = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
   assign out_valid = (state == FULL);

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant_idx == IDW'(k))
            sel_data = req_data[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (grant) state_nxt = FULL;
         FULL: begin
            if (grant)          state_nxt = FULL;
            else if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         out_data <= '0;
         out_id   <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            out_data <= sel_data ^ MASK_W;
            out_id   <= grant_idx;
            rr_ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

`ifdef XSA_STATS_EN
   logic [7:0] cnt_q [NREQ];

   // Saturating per-requester grant counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k] && cnt_q[k] != 8'hFF)
               cnt_q[k] <= cnt_q[k] + 8'd1;
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int k = 0; k < NREQ; k++) grant_cnt[k*8 +: 8] = cnt_q[k];
   end
`endif

endmodule

// File: tb/tb_xor_share_arbiter.sv
// tb/tb_xor_share_arbiter.sv - directed and randomized checks of xor_share_arbiter against a behavioural model
module tb_xor_share_arbiter;

   localparam int WIDTH = 3;
   localparam int NREQ  = 2;
   localparam int MASK  = 5;
   localparam int IDW   = 3;

   logic                  clock;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic [IDW-1:0]        out_id;
   logic                  out_ready;
`ifdef XSA_STATS_EN
   logic [NREQ*8-1:0]     grant_cnt;
`endif

   xor_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MASK(MASK), .IDW(IDW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready)
`ifdef XSA_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model state: the result register contents and the next requester to favour.
   int m_valid = 0;
   int m_data  = 0;
   int m_id    = 0;
   int m_ptr   = 0;
   int m_cnt [NREQ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int i = 0; i < NREQ; i++) begin
         if (((v >> ((p + i) % NREQ)) & 1) != 0) return (p + i) % NREQ;
      end
      return -1;
   endfunction

   // One clock: drive inputs, check combinational grant, advance model, check registered outputs.
   task automatic cycle(input bit rst, input logic [NREQ-1:0] vld,
                        input logic [NREQ*WIDTH-1:0] data, input bit ordy);
      int g;
      logic [31:0] exp_ready;
      reset = rst; req_valid = vld; req_data = data; out_ready = ordy;
      #1;
      g = -1;
      if (!rst && (m_valid == 0 || ordy)) g = pick(vld, m_ptr);
      exp_ready = (g < 0) ? 32'd0 : (32'd1 << g);
      chk("req_ready", 32'(req_ready), exp_ready);
      @(posedge clock);
      if (rst) begin
         m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0;
         for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      end else if (g >= 0) begin
         m_valid = 1;
         m_data  = (int'((data >> (g * WIDTH))) ^ MASK) & ((1 << WIDTH) - 1);
         m_id    = g;
         m_ptr   = (g + 1) % NREQ;
         if (m_cnt[g] < 255) m_cnt[g]++;
      end else if (m_valid != 0 && ordy) begin
         m_valid = 0;
      end
      @(negedge clock);
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_id", 32'(out_id), 32'(m_id));
`ifdef XSA_STATS_EN
      for (int i = 0; i < NREQ; i++)
         chk("grant_cnt", 32'(grant_cnt[i*8 +: 8]), 32'(m_cnt[i]));
`endif
   endtask

   localparam logic [NREQ*WIDTH-1:0] RR_DATA = {3'b011, 3'b000};

   initial begin
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      reset = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
      @(negedge clock);

      cycle(1, 2'b11, RR_DATA, 1);
      cycle(1, 2'b11, RR_DATA, 1);
      chk("reset_out_data", 32'(out_data), 32'd0);

      for (int i = 0; i < 6; i++) begin
         cycle(0, 2'b11, RR_DATA, 1);
         chk("rr_id", 32'(out_id), 32'(i % 2));
         chk("rr_data", 32'(out_data), (i % 2 == 0) ? 32'd5 : 32'd6);
      end

      cycle(1, 2'b00, RR_DATA, 1);
      cycle(0, 2'b11, RR_DATA, 1);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 2'b11, RR_DATA, 0);
         chk("stall_data", 32'(out_data), 32'd5);
      end
      cycle(0, 2'b11, RR_DATA, 1);
      chk("unstall_id", 32'(out_id), 32'd1);

      cycle(1, 2'b00, '0, 1);
      cycle(0, 2'b10, {3'b111, 3'b000}, 1);
      chk("drain_data", 32'(out_data), 32'd2);
      cycle(0, 2'b00, {3'b111, 3'b000}, 1);
      chk("drain_empty", 32'(out_valid), 32'd0);
      cycle(0, 2'b00, {3'b111, 3'b000}, 1);

      cycle(0, 2'b01, RR_DATA, 1);
      cycle(0, 2'b11, RR_DATA, 0);
      cycle(1, 2'b11, RR_DATA, 0);
      chk("reset_mid_stall", 32'(out_valid), 32'd0);
      cycle(0, 2'b11, RR_DATA, 1);
      chk("ptr_after_reset", 32'(out_id), 32'd0);

      for (int i = 0; i < 2000; i++) begin
         cycle(($urandom_range(0, 63) == 0), NREQ'($urandom), (NREQ*WIDTH)'($urandom),
               ($urandom_range(0, 3) != 0));
      end

`ifdef XSA_STATS_EN
      cycle(1, 2'b00, '0, 1);
      for (int i = 0; i < 300; i++) cycle(0, 2'b01, RR_DATA, 1);
      for (int i = 0; i < 3; i++) cycle(0, 2'b10, RR_DATA, 1);
      chk("cnt0_sat", 32'(grant_cnt[7:0]), 32'd255);
      chk("cnt1", 32'(grant_cnt[15:8]), 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
